// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM encoding and default geometry for the SPI-attached RAM.
package spi_ram_pkg;
   localparam int DEF_MEM_DEPTH = 256;
   localparam int DEF_ADDR_SIZE = 8;
   localparam int DEF_TX_HOLD   = 9;

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_TX_HOLD = 1'b1
   } state_e;
endpackage

// File: rtl/spi_ram_if.sv
// Command/response bundle between spi_slave (master side) and spi_ram (slave side).
interface spi_ram_if;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   modport master (output din, rx_valid, input dout, tx_valid);
   modport slave  (input din, rx_valid, output dout, tx_valid);
endinterface

// File: rtl/spi_ram_array.sv
// Single-port byte RAM, synchronous write and registered read; contents are not reset.
module spi_ram_array #(
   parameter int MEM_DEPTH = spi_ram_pkg::DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = spi_ram_pkg::DEF_ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic                 re,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata
);
   logic [7:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/spi_ram.sv
// Edge-accepted command decoder, address registers and TX_HOLD FSM around spi_ram_array.
// Optional feature: SPI_RAM_AUTOINC_EN post-increments wr_addr/rd_addr on data accesses.
module spi_ram
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int TX_HOLD   = DEF_TX_HOLD
) (
   input  logic     clk,
   input  logic     rst_n,
   spi_ram_if.slave bus
);
   logic                 rx_valid_q, accept, we, re, rd_seen;
   opcode_e              op;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, addr;
   logic [7:0]           rdata;
   state_e               state, state_nx;
   logic [3:0]           hold_cnt, cnt_nx;

   assign op     = opcode_e'(bus.din[9:8]);
   assign accept = bus.rx_valid & ~rx_valid_q;
   assign we     = accept && (op == OP_WR_DATA);
   assign re     = accept && (op == OP_RD_DATA);
   assign addr   = (op == OP_WR_DATA) ? wr_addr : rd_addr;

   spi_ram_array #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_array (
      .clk(clk), .we(we), .re(re), .addr(addr), .wdata(bus.din[7:0]), .rdata(rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_valid_q <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         rd_seen    <= 1'b0;
      end else begin
         rx_valid_q <= bus.rx_valid;
         if (accept) begin
            case (op)
               OP_WR_ADDR: wr_addr <= bus.din[ADDR_SIZE-1:0];
               OP_RD_ADDR: rd_addr <= bus.din[ADDR_SIZE-1:0];
               OP_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                  wr_addr <= wr_addr + ADDR_SIZE'(1);
`endif
               end
               OP_RD_DATA: begin
                  rd_seen <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                  rd_addr <= rd_addr + ADDR_SIZE'(1);
`endif
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         hold_cnt <= cnt_nx;
      end
   end

   // Any non-read command accepted while holding cuts the response short.
   always_comb begin
      state_nx = state;
      cnt_nx   = hold_cnt;
      if (re) begin
         state_nx = ST_TX_HOLD;
         cnt_nx   = 4'(TX_HOLD - 1);
      end else if (state == ST_TX_HOLD) begin
         if (accept || hold_cnt == 4'd0) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx = hold_cnt - 4'd1;
         end
      end
   end

   // rdata only moves on a read, so gating it with rd_seen gives a resettable, stable dout.
   always_comb begin
      bus.tx_valid = (state == ST_TX_HOLD);
      bus.dout     = rd_seen ? rdata : 8'h00;
   end
endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: directed vector table, corner sequences and random traffic vs. a command-level model.
module tb_spi_ram;
`ifdef SPI_RAM_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   localparam int TXH = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_ram_if bus();
   spi_ram dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: memory plus "remaining response cycles" counter.
   logic [7:0] m_mem [256];
   bit         m_wr  [256];
   logic [7:0] m_wa = 8'h00, m_ra = 8'h00, m_dout = 8'h00;
   bit         m_known = 1'b1;
   bit         m_prev = 1'b0;
   int         m_rem = 0;

   typedef struct {
      bit         rst;
      bit         rxv;
      logic [9:0] d;
      bit         tx;
      logic [7:0] dq;
   } vec_t;
   vec_t tv [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit v, input logic [9:0] d);
      bit acc;
      if (!r) begin
         m_wa = 8'h00; m_ra = 8'h00; m_dout = 8'h00;
         m_known = 1'b1; m_rem = 0; m_prev = 1'b0;
      end else begin
         acc = v && !m_prev;
         m_prev = v;
         if (m_rem > 0) m_rem--;
         if (acc) begin
            case (d[9:8])
               2'd0: m_wa = d[7:0];
               2'd1: begin
                  m_mem[m_wa] = d[7:0];
                  m_wr[m_wa] = 1'b1;
                  if (AUTOINC) m_wa++;
               end
               2'd2: m_ra = d[7:0];
               default: begin
                  m_dout = m_mem[m_ra];
                  m_known = m_wr[m_ra];
                  m_rem = TXH;
                  if (AUTOINC) m_ra++;
               end
            endcase
            if (d[9:8] != 2'd3) m_rem = 0;
         end
      end
   endtask

   // Called at a negedge: drive, step the model on the rising edge, compare on the next falling edge.
   task automatic tick(input bit r, input bit v, input logic [9:0] d);
      rst_n = r;
      bus.rx_valid = v;
      bus.din = d;
      @(posedge clk);
      model(r, v, d);
      @(negedge clk);
      check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, m_rem > 0});
      if (m_known) check("dout", {24'd0, bus.dout}, {24'd0, m_dout});
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] pl, output logic [7:0] q);
      tick(1'b1, 1'b1, {op, pl});
      q = bus.dout;
      tick(1'b1, 1'b0, {op, pl});
   endtask

   initial begin
      logic [7:0] q, q1, q2;
      bus.rx_valid = 1'b0;
      bus.din = '0;
      @(negedge clk);

      // Basic write-then-read, tick by tick.
      for (int i = 0; i < 17; i++) tv[i] = '{1'b1, 1'b0, 10'h000, 1'b0, 8'h00};
      tv[0] = '{1'b0, 1'b0, 10'h000, 1'b0, 8'h00};
      tv[1] = '{1'b1, 1'b1, 10'h012, 1'b0, 8'h00};
      tv[3] = '{1'b1, 1'b1, 10'h1A5, 1'b0, 8'h00};
      tv[5] = '{1'b1, 1'b1, 10'h212, 1'b0, 8'h00};
      tv[7] = '{1'b1, 1'b1, 10'h300, 1'b1, 8'hA5};
      for (int i = 8; i < 16; i++) tv[i] = '{1'b1, 1'b0, 10'h300, 1'b1, 8'hA5};
      tv[16] = '{1'b1, 1'b0, 10'h300, 1'b0, 8'hA5};
      for (int i = 0; i < 17; i++) begin
         tick(tv[i].rst, tv[i].rxv, tv[i].d);
         check($sformatf("tv%0d_tx", i), {31'd0, bus.tx_valid}, {31'd0, tv[i].tx});
         check($sformatf("tv%0d_dout", i), {24'd0, bus.dout}, {24'd0, tv[i].dq});
      end

      // Level-held rx_valid must yield exactly one write.
      cmd(2'b00, 8'h06, q); cmd(2'b01, 8'h77, q);
      cmd(2'b00, 8'h05, q);
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 10'h13C);
      tick(1'b1, 1'b0, 10'h13C);
      cmd(2'b01, 8'h99, q);
      cmd(2'b10, 8'h05, q); cmd(2'b11, 8'h00, q);
      check("hold_rd05", {24'd0, q}, {24'd0, AUTOINC ? 8'h3C : 8'h99});
      cmd(2'b10, 8'h06, q); cmd(2'b11, 8'h00, q);
      check("hold_rd06", {24'd0, q}, {24'd0, AUTOINC ? 8'h99 : 8'h77});
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 10'h000);

      // Restart on RD_DATA while holding, then abort by WR_ADDR.
      cmd(2'b00, 8'h40, q); cmd(2'b01, 8'h5A, q);
      cmd(2'b00, 8'h41, q); cmd(2'b01, 8'hC3, q);
      cmd(2'b10, 8'h40, q); cmd(2'b11, 8'h00, q);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 10'h000);
      cmd(2'b11, 8'h00, q);
      check("restart_dout", {24'd0, q}, {24'd0, AUTOINC ? 8'hC3 : 8'h5A});
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 10'h000);
      check("restart_still_tx", {31'd0, bus.tx_valid}, 32'd1);
      tick(1'b1, 1'b1, 10'h033);
      check("abort_tx", {31'd0, bus.tx_valid}, 32'd0);
      tick(1'b1, 1'b0, 10'h000);

      // Reset on cycle 4 of the hold.
      cmd(2'b10, 8'h12, q);
      tick(1'b1, 1'b1, 10'h300);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 10'h000);
      tick(1'b0, 1'b0, 10'h000);
      check("rst_tx", {31'd0, bus.tx_valid}, 32'd0);
      check("rst_dout", {24'd0, bus.dout}, 32'd0);
      cmd(2'b10, 8'h12, q); cmd(2'b11, 8'h00, q);
      check("post_rst_rd", {24'd0, q}, 32'hA5);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 10'h000);

      // Address wrap / overwrite behaviour at the top of memory.
      cmd(2'b00, 8'hFF, q); cmd(2'b01, 8'h11, q); cmd(2'b01, 8'h22, q);
      cmd(2'b10, 8'hFF, q); cmd(2'b11, 8'h00, q1); cmd(2'b11, 8'h00, q2);
      check("wrap_rd1", {24'd0, q1}, {24'd0, AUTOINC ? 8'h11 : 8'h22});
      check("wrap_rd2", {24'd0, q2}, 32'h22);

      // Random traffic, mostly in a small address window so reads hit written data.
      for (int i = 0; i < 600; i++) begin
         logic [9:0] d;
         d[9:8] = 2'($urandom_range(0, 3));
         d[7:0] = (d[9:8] == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 15));
         tick($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
